load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: FSM state encoding,
//            RV32I load/store funct3 codes, access-size codes and a helper
//            that classifies illegal funct3 values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size is carried in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Stores only exist as SB/SH/SW; loads reject 011, 110 and 111.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = f3[2] || (f3[1:0] == 2'b11);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane logic. Extracts and sign/zero-extends the
//            addressed byte/halfword/word of a memory word for loads, and
//            merges store data into the addressed lane of a read word.
//            Misaligned offsets are rounded down to natural alignment.
// Ports    : funct3     - access width/sign code
//            offset     - byte offset within the word (addr[1:0])
//            word       - memory word read back
//            wdata      - right-aligned store data
//            load_data  - extracted, extended load result
//            merge_data - word with the addressed lane replaced by wdata
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [1:0]  lane;
    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        lane = 2'b00;
        mask = 32'hFFFF_FFFF;
        case (funct3[1:0])
            SZ_BYTE: begin
                lane = offset;
                mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                lane = {offset[1], 1'b0};
                mask = 32'h0000_FFFF;
            end
            default: begin
                lane = 2'b00;
                mask = 32'hFFFF_FFFF;
            end
        endcase
        shift   = {lane, 3'b000};
        shifted = word >> shift;

        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase

        merge_data = (word & ~(mask << shift)) | ((wdata << shift) & (mask << shift));
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding RV32I load/store unit in front of a word-wide
//            data memory with combinational read and clocked write. Sub-word
//            stores are done as read-modify-write.
//            Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
//            halfword/word accesses are reported as errors; otherwise the
//            address is rounded down to natural alignment.
// Ports    : clk, rst (sync, active-high)
//            req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata - request
//            rsp_valid/rsp_rdata/rsp_error                            - response
//            mem_A/mem_WD/mem_WE/mem_RD                               - memory
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_error,
    output logic [N-1:0] mem_A,
    output logic [31:0]  mem_WD,
    output logic         mem_WE,
    input  logic [31:0]  mem_RD
);

    lsu_state_t   state, state_next;
    logic         we_q;
    logic [2:0]   funct3_q;
    logic [N+1:0] addr_q;
    logic [31:0]  wdata_q;
    logic         err_q;
    logic [31:0]  rd_word;

    logic         accept;
    logic         misalign;
    logic         req_err;
    logic [31:0]  load_data;
    logic [31:0]  merge_data;

    // Upper address bits lie outside the memory and are intentionally dropped.
    logic         unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:N+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                      ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign accept  = req_valid && (state == IDLE);
    assign req_err = funct3_illegal(req_we, req_funct3) || misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rd_word  <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[N+1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if ((state == LOAD) || (state == RMW_READ)) begin
                rd_word <= mem_RD;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!req_we) begin
                        state_next = LOAD;
                    end else if (req_funct3[1:0] == SZ_WORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_READ;
                    end
                end
            end
            LOAD:     state_next = RESP;
            RMW_READ: state_next = WRITE;
            WRITE:    state_next = RESP;
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .word       (rd_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign mem_A     = addr_q[N+1:2];
    // Gated by rst so an in-flight store cannot land while reset is applied.
    assign mem_WE    = (state == WRITE) && !rst;
    assign mem_WD    = (state == WRITE) ? (we_q && (funct3_q[1:0] == SZ_WORD) ? wdata_q : merge_data)
                                        : 32'h0;
    assign rsp_error = (state == RESP) && err_q;
    assign rsp_rdata = ((state == RESP) && !we_q && !err_q) ? load_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. A byte-addressed
//            reference memory predicts load results, errors, latencies and
//            the resulting memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int N = 8;
    localparam int WORDS = 1 << N;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [2:0]   req_funct3;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_error;
    logic [N-1:0] mem_A;
    logic [31:0]  mem_WD;
    logic         mem_WE;
    logic [31:0]  mem_RD;

    logic [31:0]  tbmem [0:WORDS-1];
    logic [7:0]   refb  [0:4*WORDS-1];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;
    logic [N-1:0] last_wa = '0;
    logic [31:0]  last_rdata;
    logic         last_err;

    load_store_unit #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = tbmem[mem_A];

    always @(posedge clk) begin
        if (mem_WE) begin
            tbmem[mem_A] = mem_WD;
            last_wa = mem_A;
            we_cnt = we_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic exp_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        if (we) bad = (f3 > 3'd2);
        else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!bad && (int'(a[1:0]) % nbytes(f3) != 0)) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic int base_of(input logic [2:0] f3, input logic [31:0] a);
        int b;
        b = int'(a[N+1:0]);
        return b - (b % nbytes(f3));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int b, nb;
        logic [31:0] v;
        b = base_of(f3, a);
        nb = nbytes(f3);
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (32'(refb[b + i]) << (8 * i));
        if (!f3[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int b;
        b = base_of(f3, a);
        for (int i = 0; i < nbytes(f3); i++) refb[b + i] = 8'(d >> (8 * i));
    endtask

    // ---------------- one request, checked end to end ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        logic        e;
        logic [31:0] exp_d;
        int          exp_lat, exp_w, lat, w0, r0, k, wi;
        e = exp_illegal(we, f3, a);
        exp_d = (we || e) ? 32'h0 : ref_load(f3, a);
        if (e)                exp_lat = 1;
        else if (!we)         exp_lat = 2;
        else if (f3 == 3'd2)  exp_lat = 2;
        else                  exp_lat = 3;
        exp_w = (we && !e) ? 1 : 0;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        w0 = we_cnt;
        r0 = rsp_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
        check({tag, "_lat"},   32'(lat),        32'(exp_lat));
        check({tag, "_err"},   32'(rsp_error),  32'(e));
        check({tag, "_rdata"}, rsp_rdata,       exp_d);
        @(posedge clk);
        #1;
        check({tag, "_writes"}, 32'(we_cnt - w0),  32'(exp_w));
        check({tag, "_rsps"},   32'(rsp_cnt - r0), 32'd1);
        if (exp_w == 1) begin
            ref_store(f3, a, d);
            wi = base_of(f3, a) / 4;
            check({tag, "_waddr"}, 32'(last_wa),  32'(wi));
            check({tag, "_mem"},   tbmem[wi],     ref_word(wi));
        end
    endtask

    initial begin
        int acc, rsps, w0, r0;
        logic [31:0] exp_d, tmp;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            tmp = $urandom;
            tbmem[i] = tmp;
            for (int j = 0; j < 4; j++) refb[4*i + j] = 8'(tmp >> (8 * j));
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", 32'(mem_WE), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready",  32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(rsp_valid), 32'd0);
        check("rst_rdata",  rsp_rdata,      32'h0);
        check("rst_rerr",   32'(rsp_error), 32'd0);
        check("rst_mem_a",  32'(mem_A),     32'd0);
        check("rst_mem_wd", mem_WD,         32'h0);

        // Word store then load back
        do_req(1'b1, 3'd2, 32'h58, 32'h2B345FD4, "sw58");
        check("sw58_word", tbmem[22], 32'h2B345FD4);
        do_req(1'b0, 3'd2, 32'h58, 32'h0, "lw58");
        check("lw58_val", last_rdata, 32'h2B345FD4);

        // Byte store and byte loads
        do_req(1'b1, 3'd0, 32'h59, 32'h000000AA, "sb59");
        check("sb59_word", tbmem[22], 32'h2B34AAD4);
        do_req(1'b0, 3'd0, 32'h59, 32'h0, "lb59");
        check("lb59_val", last_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 3'd4, 32'h59, 32'h0, "lbu59");
        check("lbu59_val", last_rdata, 32'h000000AA);

        // Halfword store and halfword loads
        do_req(1'b1, 3'd1, 32'h5A, 32'h00008001, "sh5a");
        check("sh5a_word", tbmem[22], 32'h8001AAD4);
        do_req(1'b0, 3'd1, 32'h5A, 32'h0, "lh5a");
        check("lh5a_val", last_rdata, 32'hFFFF8001);
        do_req(1'b0, 3'd5, 32'h5A, 32'h0, "lhu5a");
        check("lhu5a_val", last_rdata, 32'h00008001);

        // Misaligned word load
        do_req(1'b0, 3'd2, 32'h5A, 32'h0, "lw5a");
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw5a_trap", 32'(last_err), 32'd1);
`else
        check("lw5a_val", last_rdata, 32'h8001AAD4);
`endif

        // Illegal store: error, memory untouched
        do_req(1'b1, 3'd4, 32'h58, 32'h12345678, "sbad");
        check("sbad_word", tbmem[22], 32'h8001AAD4);

        // Reset in the middle of a word store
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
        w0 = we_cnt;
        r0 = rsp_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_we_low", 32'(mem_WE), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_writes", 32'(we_cnt - w0),  32'd0);
        check("abort_rsps",   32'(rsp_cnt - r0), 32'd0);
        check("abort_ready",  32'(req_ready),    32'd1);
        check("abort_mem",    tbmem[64],         ref_word(64));

        // req_valid held high: one accept per three cycles, one response each
        exp_d = ref_load(3'd2, 32'h58);
        acc = 0;
        rsps = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h58;
        for (int i = 0; i < 30; i++) begin
            if (req_ready && rsp_valid) begin
                check("held_overlap", 32'd1, 32'd0);
            end
            if (req_ready) acc++;
            if (rsp_valid) begin
                rsps++;
                check("held_rdata", rsp_rdata, exp_d);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("held_accepts", 32'(acc),  32'd10);
        check("held_rsps",    32'(rsps), 32'd10);
        @(negedge clk);

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            do_req(1'($urandom), 3'($urandom), $urandom, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
